// File: rtl/hd_ctrl_pkg.sv
// Shared definitions for the HD save/load controllers: state encoding and
// default slot geometry.
package hd_ctrl_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    LER      = 2'd1,
    ESCREVER = 2'd2,
    FIM      = 2'd3
  } hd_state_t;

  localparam int PROG_SIZE_DEFAULT = 150;
  localparam int HD_OFFSET_DEFAULT = 200;
  localparam int RAM_BASE_DEFAULT  = 550;

endpackage

// File: rtl/controlador_salva_hd.sv
// Copies one PROG_SIZE-word program image from RAM into an HD slot.
// Optional running checksum output enabled with HD_SAVE_CHECKSUM_EN.
import hd_ctrl_pkg::*;

// state    | meaning
// OCIOSO   | idle, waiting for Store_to_HD
// LER      | RAM read issued, data arrives next cycle
// ESCREVER | hd_wr_en high, waiting for hd_wr_ready
// FIM      | last word written, concluido pulse
module controlador_salva_hd #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int PROG_SIZE  = PROG_SIZE_DEFAULT,
  parameter int HD_OFFSET  = HD_OFFSET_DEFAULT,
  parameter int RAM_BASE   = RAM_BASE_DEFAULT
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Store_to_HD,
  input  logic [ADDR_WIDTH-1:0] indice_programa,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  input  logic                  hd_wr_ready,
  output logic [ADDR_WIDTH-1:0] endereco_RAM,
  output logic [ADDR_WIDTH-1:0] endereco_HD,
  output logic [DATA_WIDTH-1:0] hd_wr_data,
  output logic                  hd_wr_en,
  output logic                  salvando,
  output logic                  concluido
`ifdef HD_SAVE_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] soma
`endif
);

  localparam int CNT_W = (PROG_SIZE > 1) ? $clog2(PROG_SIZE) : 1;
  localparam logic [ADDR_WIDTH-1:0] L_PROG_SIZE = ADDR_WIDTH'(PROG_SIZE);
  localparam logic [ADDR_WIDTH-1:0] L_HD_OFFSET = ADDR_WIDTH'(HD_OFFSET);
  localparam logic [ADDR_WIDTH-1:0] L_RAM_BASE  = ADDR_WIDTH'(RAM_BASE);
  localparam logic [CNT_W-1:0]      L_LAST      = CNT_W'(PROG_SIZE - 1);

  hd_state_t             r_state;
  hd_state_t             w_next;
  logic [ADDR_WIDTH-1:0] r_addr_ram;
  logic [ADDR_WIDTH-1:0] r_addr_hd;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] w_hd_base;
  logic                  w_start;
  logic                  w_xfer;
  logic                  w_last;

  // Only the low ADDR_WIDTH bits of the product matter, so the
  // truncated multiply gives the same result as wrapping the full one.
  assign w_hd_base = indice_programa * L_PROG_SIZE + L_HD_OFFSET;
  assign w_last    = (r_cnt == L_LAST);

  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_xfer    = 1'b0;
    hd_wr_en  = 1'b0;
    salvando  = 1'b1;
    concluido = 1'b0;
    case (r_state)
      OCIOSO: begin
        salvando = 1'b0;
        if (Store_to_HD) begin
          w_start = 1'b1;
          w_next  = LER;
        end
      end
      LER: w_next = ESCREVER;
      ESCREVER: begin
        hd_wr_en = 1'b1;
        if (hd_wr_ready) begin
          w_xfer = 1'b1;
          w_next = w_last ? FIM : LER;
        end
      end
      FIM: begin
        concluido = 1'b1;
        w_next    = OCIOSO;
      end
      default: w_next = OCIOSO;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state    <= OCIOSO;
      r_addr_ram <= '0;
      r_addr_hd  <= '0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_addr_ram <= L_RAM_BASE;
        r_addr_hd  <= w_hd_base;
        r_cnt      <= '0;
      end else if (w_xfer && !w_last) begin
        r_addr_ram <= r_addr_ram + 1'b1;
        r_addr_hd  <= r_addr_hd + 1'b1;
        r_cnt      <= r_cnt + 1'b1;
      end
    end
  end

  assign endereco_RAM = r_addr_ram;
  assign endereco_HD  = r_addr_hd;
  assign hd_wr_data   = ram_rd_data;

`ifdef HD_SAVE_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_soma;

  always_ff @(posedge Clock) begin
    if (Reset || w_start)
      r_soma <= '0;
    else if (w_xfer)
      r_soma <= r_soma + ram_rd_data;
  end

  assign soma = r_soma;
`endif

endmodule

// File: doc/controlador_salva_hd.md
CONTROLADOR_SALVA_HD -- requirements
Module: controlador_salva_hd

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, width of all RAM/HD address ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-003 SHALL have parameter PROG_SIZE, default 150, words per program slot and per save.
REQ-004 SHALL have parameter HD_OFFSET, default 200, HD address of slot 0.
REQ-005 SHALL have parameter RAM_BASE, default 550, first RAM word saved.
REQ-006 SHALL have port Clock, input, 1, system clock; all state changes on rising edge.
REQ-007 SHALL have port Reset, input, 1, synchronous, active-high.
REQ-008 SHALL have port Store_to_HD, input, 1, start request, sampled only in OCIOSO.
REQ-009 SHALL have port indice_programa, input, ADDR_WIDTH, destination slot, sampled with start.
REQ-010 SHALL have port ram_rd_data, input, DATA_WIDTH, synchronous RAM read data, 1-cycle latency from endereco_RAM.
REQ-011 SHALL have port hd_wr_ready, input, 1, HD accepts write this cycle.
REQ-012 SHALL have port endereco_RAM, output, ADDR_WIDTH, RAM read address, registered.
REQ-013 SHALL have port endereco_HD, output, ADDR_WIDTH, HD write address, registered.
REQ-014 SHALL have port hd_wr_data, output, DATA_WIDTH, driven directly from ram_rd_data.
REQ-015 SHALL have port hd_wr_en, output, 1, write valid; high exactly in ESCREVER.
REQ-016 SHALL have port salvando, output, 1, busy; high from LER through FIM.
REQ-017 SHALL have port concluido, output, 1, one-cycle pulse in FIM.

Function
REQ-018 States SHALL be OCIOSO, LER, ESCREVER, FIM.
REQ-019 OCIOSO with Store_to_HD=1: endereco_RAM<=RAM_BASE, endereco_HD<=(indice_programa*PROG_SIZE+HD_OFFSET) truncated to ADDR_WIDTH, word counter<=0, -> LER.
REQ-020 LER SHALL last one cycle, addresses held, -> ESCREVER.
REQ-021 ESCREVER SHALL hold both addresses constant so ram_rd_data stays valid while stalled.
REQ-022 Word transfer SHALL occur on an edge with hd_wr_en=1 and hd_wr_ready=1; each word written exactly once.
REQ-023 On transfer with counter<PROG_SIZE-1: both addresses +1, counter +1, -> LER; with counter=PROG_SIZE-1: -> FIM, addresses unchanged.
REQ-024 FIM SHALL last one cycle (concluido=1, salvando=1), -> OCIOSO with salvando=0.
REQ-025 With hd_wr_ready tied high, word k SHALL be accepted at edge 2k+2 after the sampling edge; concluido high in the cycle after edge 2*PROG_SIZE.
REQ-026 Store_to_HD outside OCIOSO SHALL be ignored, not queued.
REQ-027 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH; no saturation or error.

Reset
REQ-028 Reset=1 SHALL, at the next edge, from any state, force OCIOSO and endereco_RAM, endereco_HD, counter, salvando, concluido to 0; hd_wr_en 0 from that cycle; Reset overrides Store_to_HD.
REQ-029 An aborted save SHALL produce no further writes and no concluido.

Configuration
REQ-030 With HD_SAVE_CHECKSUM_EN defined: extra output soma, DATA_WIDTH, cleared on start, += hd_wr_data on each transfer modulo 2^DATA_WIDTH, final value stable from FIM until next start.
REQ-031 Without HD_SAVE_CHECKSUM_EN: soma port and accumulator absent; all other behaviour identical.

Structure
REQ-032 Package hd_ctrl_pkg SHALL hold the state enum and default constants PROG_SIZE, HD_OFFSET, RAM_BASE, shared with the HD load controller.
REQ-033 Single flat module; no sub-module; checksum accumulator inline.

Verification
REQ-034 indice=2, ready=1, RAM[a]=a -> 150 writes HD 500..649 with data 550..699; concluido after edge 300.
REQ-035 ready low 3 cycles during word 5 -> hd_wr_en held, endereco_HD=505, data 555 stable, single write.
REQ-036 Store_to_HD pulsed again at cycle 20 -> ignored, exactly 150 writes, one concluido.
REQ-037 Reset during word 40 -> next cycle hd_wr_en=0, salvando=0, addresses 0, no writes after.
REQ-038 indice=30 -> HD base (4500+200) mod 4096 = 604.
REQ-039 HD_SAVE_CHECKSUM_EN, scenario REQ-034 -> soma=93675 at concluido.
